// File: rtl/instr_enc_pkg.sv
// Package: instr_enc_pkg
// Shared definitions for the RV32I field-level instruction encoder:
//   - instruction class codes carried on in_class
//   - major opcodes (the control decoder uses the same values)
//   - canonical NOP (addi x0,x0,0)
//   - encode_fields(): packs one request into a 32-bit instruction word
package instr_enc_pkg;

   localparam logic [2:0] CLS_R      = 3'd0;
   localparam logic [2:0] CLS_I      = 3'd1;
   localparam logic [2:0] CLS_LOAD   = 3'd2;
   localparam logic [2:0] CLS_STORE  = 3'd3;
   localparam logic [2:0] CLS_BRANCH = 3'd4;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [31:0] NOP = 32'h0000_0013;

   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SRX = 3'b101;

   // Illegal classes fall back to NOP; immediate bits outside a format's
   // field are simply not used.
   function automatic logic [31:0] encode_fields(
      input logic [2:0]  cls,
      input logic [2:0]  f3,
      input logic        f7b5,
      input logic [4:0]  rd,
      input logic [4:0]  rs1,
      input logic [4:0]  rs2,
      input logic [12:0] imm
   );
      logic [31:0] w;
      w = NOP;
      case (cls)
         CLS_R:      w = {1'b0, f7b5, 5'b0, rs2, rs1, f3, rd, OP_R};
         CLS_I: begin
            // Shifts reuse the R-type funct7 slot; only imm[4:0] is shamt.
            if (f3 == F3_SLL || f3 == F3_SRX)
               w = {1'b0, f7b5, 5'b0, imm[4:0], rs1, f3, rd, OP_I};
            else
               w = {imm[11:0], rs1, f3, rd, OP_I};
         end
         CLS_LOAD:   w = {imm[11:0], rs1, f3, rd, OP_LOAD};
         CLS_STORE:  w = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
         CLS_BRANCH: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
         default:    w = NOP;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Module: enc_fifo
// Synchronous FIFO holding encoded words until the consumer takes them.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   flush           synchronous clear (pointers and count)
//   push, push_data write side; a push while full is ignored
//   full            occupancy == DEPTH
//   pop             read side; advances only when an entry is present
//   pop_valid       FIFO not empty
//   pop_data        current head entry (stable until popped)
//   cnt             current occupancy
module enc_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   output logic                     full,
   input  logic                     pop,
   output logic                     pop_valid,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   cnt
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      cnt_q;
   logic             push_ok;
   logic             pop_ok;

   assign full      = (cnt_q == (PW+1)'(DEPTH));
   assign pop_valid = (cnt_q != '0);
   assign pop_data  = mem[rd_ptr];
   assign cnt       = cnt_q;
   assign push_ok   = push & ~full;
   assign pop_ok    = pop & pop_valid;

   // Storage is not reset; only the pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// Module: instr_encoder
// Packs {class, funct3, funct7b5, rd, rs1, rs2, imm} requests into RV32I
// words and hands them out through a small FIFO, each tagged with a
// sequential instruction-memory word address.
// Optional feature macro: ENC_CHECK_EN (request legality check + enc_err).
// Ports:
//   clk, rst_n        clock, synchronous active-low reset (wins over flush)
//   flush             clears FIFO and address counter; blocks input that cycle
//   in_valid/in_ready request handshake; in_ready = !full & !flush
//   in_class..in_imm  request fields
//   out_valid/out_ready output handshake
//   out_instr         FIFO head word (0 when empty)
//   out_addr          word address of out_instr; wraps to 0
//   fifo_cnt          FIFO occupancy
//   enc_err           (ENC_CHECK_EN only) sticky illegal-request flag
module instr_encoder
   import instr_enc_pkg::*;
#(
   parameter int               ADDR_W     = 10,
   parameter int               FIFO_DEPTH = 4,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [2:0]                    in_class,
   input  logic [2:0]                    in_funct3,
   input  logic                          in_funct7b5,
   input  logic [4:0]                    in_rd,
   input  logic [4:0]                    in_rs1,
   input  logic [4:0]                    in_rs2,
   input  logic [12:0]                   in_imm,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [31:0]                   out_instr,
   output logic [ADDR_W-1:0]             out_addr,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
`ifdef ENC_CHECK_EN
   ,
   output logic                          enc_err
`endif
);

   logic        fifo_full;
   logic        push;
   logic        pop;
   logic [31:0] enc_word;
   logic [31:0] head;

   // No pass-through: a pop while full does not open the input this cycle.
   assign in_ready = ~fifo_full & ~flush;
   assign pop      = out_valid & out_ready;
   assign enc_word = encode_fields(in_class, in_funct3, in_funct7b5,
                                   in_rd, in_rs1, in_rs2, in_imm);

`ifdef ENC_CHECK_EN
   logic legal;

   always_comb begin
      legal = 1'b1;
      if (in_class > CLS_BRANCH)
         legal = 1'b0;
      else if (in_class == CLS_BRANCH && in_imm[0])
         legal = 1'b0;
      else if ((in_class == CLS_I || in_class == CLS_LOAD || in_class == CLS_STORE)
               && (in_imm[12] != in_imm[11]))
         legal = 1'b0;
   end

   // Illegal requests are consumed (handshake completes) but dropped.
   assign push = in_valid & in_ready & legal;

   always_ff @(posedge clk) begin
      if (!rst_n)
         enc_err <= 1'b0;
      else if (in_valid && in_ready && !legal)
         enc_err <= 1'b1;
   end
`else
   assign push = in_valid & in_ready;
`endif

   enc_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (push),
      .push_data (enc_word),
      .full      (fifo_full),
      .pop       (pop),
      .pop_valid (out_valid),
      .pop_data  (head),
      .cnt       (fifo_cnt)
   );

   assign out_instr = out_valid ? head : '0;

   // Natural binary wrap: the counter rolls to 0, not back to BASE_ADDR.
   always_ff @(posedge clk) begin
      if (!rst_n)
         out_addr <= BASE_ADDR;
      else if (flush)
         out_addr <= BASE_ADDR;
      else if (pop)
         out_addr <= out_addr + 1'b1;
   end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [2:0]  in_class = '0;
   logic [2:0]  in_funct3 = '0;
   logic        in_funct7b5 = 1'b0;
   logic [4:0]  in_rd = '0;
   logic [4:0]  in_rs1 = '0;
   logic [4:0]  in_rs2 = '0;
   logic [12:0] in_imm = '0;
   logic        out_ready;
   logic        fixed_rdy = 1'b0;
   logic        rand_rdy = 1'b0;
   logic        rnd_rdy = 1'b0;

   logic        in_ready, out_valid;
   logic [31:0] out_instr;
   logic [9:0]  out_addr;
   logic [2:0]  fifo_cnt;
   logic        in_ready_s, out_valid_s;
   logic [31:0] out_instr_s;
   logic [1:0]  out_addr_s;
   logic [2:0]  fifo_cnt_s;
`ifdef ENC_CHECK_EN
   logic        enc_err, enc_err_s;
`endif

   assign out_ready = rand_rdy ? rnd_rdy : fixed_rdy;

   always #5 clk = ~clk;

   instr_encoder u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_class(in_class), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr), .fifo_cnt(fifo_cnt)
`ifdef ENC_CHECK_EN
      , .enc_err(enc_err)
`endif
   );

   instr_encoder #(.ADDR_W(2), .FIFO_DEPTH(4), .BASE_ADDR(2'd1)) u_small (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_s),
      .in_class(in_class), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .out_valid(out_valid_s), .out_ready(out_ready),
      .out_instr(out_instr_s), .out_addr(out_addr_s), .fifo_cnt(fifo_cnt_s)
`ifdef ENC_CHECK_EN
      , .enc_err(enc_err_s)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Reference encoder built from field positions with shifts and masks.
   function automatic logic [31:0] ref_enc(input int unsigned c, input int unsigned f3,
                                           input int unsigned f7, input int unsigned rd,
                                           input int unsigned rs1, input int unsigned rs2,
                                           input int unsigned imm);
      int unsigned regs;
      int unsigned w;
      regs = (rs1 << 15) | (f3 << 12);
      case (c)
         0: w = (f7 << 30) | (rs2 << 20) | regs | (rd << 7) | 51;
         1: if (f3 == 1 || f3 == 5) w = (f7 << 30) | ((imm & 31) << 20) | regs | (rd << 7) | 19;
            else                    w = ((imm & 4095) << 20) | regs | (rd << 7) | 19;
         2: w = ((imm & 4095) << 20) | regs | (rd << 7) | 3;
         3: w = (((imm >> 5) & 127) << 25) | (rs2 << 20) | regs | ((imm & 31) << 7) | 35;
         4: w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20) | regs
                | (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7) | 99;
         default: w = 32'h13;
      endcase
      return w;
   endfunction

`ifdef ENC_CHECK_EN
   function automatic bit ref_legal(input int unsigned c, input int unsigned imm);
      if (c > 4) return 1'b0;
      if (c == 4 && (imm & 1) != 0) return 1'b0;
      if (c >= 1 && c <= 3 && ((imm >> 12) & 1) != ((imm >> 11) & 1)) return 1'b0;
      return 1'b1;
   endfunction
   bit exp_err = 1'b0;
`endif

   logic [31:0] mq[$];
   int unsigned m_addr = 0;
   int unsigned m_addr_s = 1;
   logic [31:0] got_instr[$];
   int unsigned got_addr[$];

   always @(posedge clk) begin
      #1;
      rnd_rdy = 1'($urandom_range(0, 1));
   end

   // Scoreboard: compare outputs, then apply the handshakes of the coming edge.
   always @(negedge clk) begin
      bit m_valid, m_ready;
      if (!rst_n) begin
         mq.delete();
         m_addr = 0;
         m_addr_s = 1;
`ifdef ENC_CHECK_EN
         exp_err = 1'b0;
`endif
      end else begin
         m_valid = (mq.size() != 0);
         m_ready = (mq.size() < 4) && !flush;
         check("out_valid", 32'(out_valid), 32'(m_valid));
         check("fifo_cnt", 32'(fifo_cnt), 32'(mq.size()));
         check("in_ready", 32'(in_ready), 32'(m_ready));
         check("out_valid_s", 32'(out_valid_s), 32'(m_valid));
         check("fifo_cnt_s", 32'(fifo_cnt_s), 32'(mq.size()));
         check("in_ready_s", 32'(in_ready_s), 32'(m_ready));
`ifdef ENC_CHECK_EN
         check("enc_err", 32'(enc_err), 32'(exp_err));
         check("enc_err_s", 32'(enc_err_s), 32'(exp_err));
`endif
         if (m_valid) begin
            check("out_instr", out_instr, mq[0]);
            check("out_addr", 32'(out_addr), m_addr);
            check("out_instr_s", out_instr_s, mq[0]);
            check("out_addr_s", 32'(out_addr_s), m_addr_s);
         end
         if (flush) begin
            mq.delete();
            m_addr = 0;
            m_addr_s = 1;
         end else begin
            if (m_valid && out_ready) begin
               got_instr.push_back(mq[0]);
               got_addr.push_back(m_addr);
               void'(mq.pop_front());
               m_addr = (m_addr + 1) % 1024;
               m_addr_s = (m_addr_s + 1) % 4;
            end
            if (in_valid && m_ready) begin
`ifdef ENC_CHECK_EN
               if (!ref_legal(in_class, in_imm)) exp_err = 1'b1;
               else mq.push_back(ref_enc(in_class, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm));
`else
               mq.push_back(ref_enc(in_class, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm));
`endif
            end
         end
      end
   end

   task automatic send(input logic [2:0] c, input logic [2:0] f3, input logic f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [12:0] imm);
      bit ok;
      in_class = c; in_funct3 = f3; in_funct7b5 = f7;
      in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      in_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("send_accept", 32'(ok), 32'd1);
   endtask

   task automatic drain();
      for (int k = 0; k < 300; k++) begin
         @(negedge clk); #1;
         if (mq.size() == 0) break;
      end
      check("drain_empty", 32'(mq.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      // Reset state
      tick(3);
      rst_n = 1'b1;
      @(negedge clk); #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
      check("rst_out_addr", 32'(out_addr), 32'd0);
      check("rst_out_addr_s", 32'(out_addr_s), 32'd1);
      @(posedge clk); #1;

      // Known encodings
      fixed_rdy = 1'b1;
      b = got_instr.size();
      send(3'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 13'd5);
      send(3'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 13'd0);
      send(3'd0, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 13'd0);
      send(3'd2, 3'b010, 1'b0, 5'd5, 5'd2, 5'd0, 13'd8);
      send(3'd3, 3'b010, 1'b0, 5'd0, 5'd2, 5'd5, 13'd12);
      send(3'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 13'h1FFC);
      drain();
      check("addi", got_instr[b+0], 32'h00500093);
      check("add",  got_instr[b+1], 32'h002081B3);
      check("sub",  got_instr[b+2], 32'h402081B3);
      check("lw",   got_instr[b+3], 32'h00812283);
      check("sw",   got_instr[b+4], 32'h00512623);
      check("beq",  got_instr[b+5], 32'hFE208EE3);
      for (int i = 0; i < 6; i++) check("addr_seq", got_addr[b+i], 32'(i));

      // Backpressure: four words fill the FIFO, the fifth waits
      fixed_rdy = 1'b0;
      b = got_instr.size();
      for (int i = 0; i < 4; i++) send(3'd1, 3'b000, 1'b0, 5'(i + 1), 5'd0, 5'd0, 13'(i + 20));
      @(negedge clk); #1;
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_cnt", 32'(fifo_cnt), 32'd4);
      @(posedge clk); #1;
      fixed_rdy = 1'b1;
      send(3'd1, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 13'd24);
      drain();
      for (int i = 0; i < 5; i++) begin
         check("bp_order", got_instr[b+i], 32'h00000013 | (32'(i + 20) << 20) | (32'(i + 1) << 7));
         check("bp_addr", got_addr[b+i], 32'(6 + i));
      end

      // Flush mid-stream with a request presented in the same cycle
      fixed_rdy = 1'b0;
      for (int i = 0; i < 3; i++) send(3'd0, 3'b111, 1'b0, 5'd7, 5'd8, 5'd9, 13'd0);
      flush = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk); #1;
      check("flush_cnt", 32'(fifo_cnt), 32'd0);
      check("flush_addr", 32'(out_addr), 32'd0);
      check("flush_addr_s", 32'(out_addr_s), 32'd1);
      @(posedge clk); #1;
      fixed_rdy = 1'b1;
      b = got_instr.size();
      send(3'd2, 3'b000, 1'b0, 5'd4, 5'd3, 5'd0, 13'd16);
      drain();
      check("post_flush_addr", got_addr[b], 32'd0);

      // Reset mid-stream
      fixed_rdy = 1'b0;
      send(3'd0, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 13'd0);
      send(3'd0, 3'b000, 1'b0, 5'd2, 5'd2, 5'd2, 13'd0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk); #1;
      check("mid_rst_cnt", 32'(fifo_cnt), 32'd0);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_instr", out_instr, 32'd0);
      @(posedge clk); #1;

      // Illegal class / misaligned branch
      fixed_rdy = 1'b1;
      b = got_instr.size();
      send(3'd6, 3'b000, 1'b0, 5'd9, 5'd9, 5'd9, 13'd0);
`ifdef ENC_CHECK_EN
      send(3'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 13'h1FFD);
      tick(2);
      check("illegal_no_word", 32'(got_instr.size() - b), 32'd0);
      check("illegal_err", 32'(enc_err), 32'd1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk); #1;
      check("err_kept_flush", 32'(enc_err), 32'd1);
      @(posedge clk); #1;
`else
      drain();
      check("illegal_nop", got_instr[b], 32'h00000013);
      check("illegal_nop_addr", got_addr[b], 32'd0);
`endif

      // Randomized traffic with random consumer backpressure
      rand_rdy = 1'b1;
      for (int i = 0; i < 1200; i++)
         send(3'($urandom_range(0, 7)), 3'($urandom), 1'($urandom), 5'($urandom),
              5'($urandom), 5'($urandom), 13'($urandom));
      rand_rdy = 1'b0;
      fixed_rdy = 1'b1;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
